// File: rtl/cpu_bus_arbiter_if.sv
// SRAM-like bus: a request channel (req/wr/size/wstrb/addr/wdata) answered by
// addr_ok, and a response channel (data_ok/rdata).
// Handshake: a request is accepted on the rising edge where req and addr_ok are
// both 1; the requester holds req and its fields stable until then. A data_ok
// pulse returns exactly one response, in the order the requests were accepted.
interface cpu_bus_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    // Issuer of requests.
    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    // Receiver of requests.
    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/cpu_bus_arbiter.sv
// Two-to-one arbiter: the CPU instruction and data ports share one SRAM-like
// slave. Data has fixed priority. A request that is waiting for addr_ok keeps
// its grant, so the slave never sees its request change mid-handshake. An
// in-order tag FIFO remembers the issuer of every accepted request so that each
// slave data_ok can be steered back to that issuer.
module cpu_bus_arbiter #(
    parameter int OUTSTANDING = 2
) (
    input  logic                          clk,
    input  logic                          resetn,
    cpu_bus_arbiter_if.slave              inst,
    cpu_bus_arbiter_if.slave              data,
    cpu_bus_arbiter_if.master             s,
    output logic                          dbg_lock,
    output logic [$clog2(OUTSTANDING):0]  dbg_count,
    output logic                          dbg_head
);
    localparam int AW = $clog2(OUTSTANDING);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(OUTSTANDING);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic          lock_sel, lock_sel_nxt;   // 1 = data master holds the lock
    logic          gnt_data, gnt_inst, granted_req;
    logic          fifo_full, fifo_empty, push, pop, head;
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic          tags [OUTSTANDING];       // 1 = data, 0 = instruction

    // Grant: fixed data priority, overridden by the locked master.
    always_comb begin
        gnt_data = data.req;
        gnt_inst = inst.req & ~data.req;
        if (state == ST_LOCK) begin
            gnt_data = lock_sel;
            gnt_inst = ~lock_sel;
        end
    end

    assign granted_req = (gnt_data & data.req) | (gnt_inst & inst.req);
    assign fifo_full   = (count == CNT_FULL);
    assign fifo_empty  = (count == '0);

    // A full tag FIFO holds off new requests; reset forces the bus quiet.
    assign s.req   = resetn & granted_req & ~fifo_full;
    assign s.wr    = gnt_data ? data.wr    : inst.wr;
    assign s.size  = gnt_data ? data.size  : inst.size;
    assign s.wstrb = gnt_data ? data.wstrb : inst.wstrb;
    assign s.addr  = gnt_data ? data.addr  : inst.addr;
    assign s.wdata = gnt_data ? data.wdata : inst.wdata;

    assign inst.addr_ok = s.addr_ok & s.req & gnt_inst;
    assign data.addr_ok = s.addr_ok & s.req & gnt_data;

    assign push = s.req & s.addr_ok;
    // A data_ok with nothing outstanding is spurious and dropped.
    assign pop  = s.data_ok & ~fifo_empty;
    assign head = tags[rptr];

    assign data.data_ok = pop & head;
    assign inst.data_ok = pop & ~head;
    assign inst.rdata   = s.rdata;
    assign data.rdata   = s.rdata;

    assign dbg_lock  = (state == ST_LOCK);
    assign dbg_count = count;
    assign dbg_head  = head;

    // Lock FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            lock_sel <= 1'b0;
        end else begin
            state    <= state_nxt;
            lock_sel <= lock_sel_nxt;
        end
    end

    // Lock FSM next state: lock while the slave stalls a presented request.
    always_comb begin
        state_nxt    = state;
        lock_sel_nxt = lock_sel;
        case (state)
            ST_IDLE: begin
                if (s.req && !s.addr_ok) begin
                    state_nxt    = ST_LOCK;
                    lock_sel_nxt = gnt_data;
                end
            end
            ST_LOCK: begin
                // Accepted, or the locked master withdrew its request.
                if (s.addr_ok || !s.req) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Tag FIFO pointers and occupancy; push and pop together keep count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Tag storage; contents only matter below count, so no reset.
    always_ff @(posedge clk) begin
        if (push) tags[wptr] <= gnt_data;
    end
endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Bench for cpu_bus_arbiter: vector table, directed multi-cycle sequences and
// a random run against a queue-based reference model.
module tb_cpu_bus_arbiter;
    localparam int OUTSTANDING = 2;

    // Clock and reset.
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    cpu_bus_arbiter_if inst_bus ();
    cpu_bus_arbiter_if data_bus ();
    cpu_bus_arbiter_if s_bus ();

    logic       dbg_lock;
    logic [1:0] dbg_count;
    logic       dbg_head;

    cpu_bus_arbiter #(.OUTSTANDING(OUTSTANDING)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .inst      (inst_bus),
        .data      (data_bus),
        .s         (s_bus),
        .dbg_lock  (dbg_lock),
        .dbg_count (dbg_count),
        .dbg_head  (dbg_head)
    );

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic       rst_n, i_req, d_req, aok, dok;
        logic       e_sreq, e_sel_d, e_iaok, e_daok;
        logic [1:0] e_count;
    } vec_t;

    vec_t vecs [8];

    function automatic vec_t mk(input logic r, i, d, a, k, es, sd, ei, ed,
                                input logic [1:0] ec);
        vec_t v;
        v.rst_n = r; v.i_req = i; v.d_req = d; v.aok = a; v.dok = k;
        v.e_sreq = es; v.e_sel_d = sd; v.e_iaok = ei; v.e_daok = ed;
        v.e_count = ec;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Driver tasks.
    task automatic idle_inputs();
        inst_bus.req = 1'b0; inst_bus.wr = 1'b0; inst_bus.size = 2'b10;
        inst_bus.wstrb = 4'hF; inst_bus.addr = 32'h0; inst_bus.wdata = 32'h0;
        data_bus.req = 1'b0; data_bus.wr = 1'b1; data_bus.size = 2'b01;
        data_bus.wstrb = 4'h3; data_bus.addr = 32'h0; data_bus.wdata = 32'h0;
        s_bus.addr_ok = 1'b0; s_bus.data_ok = 1'b0; s_bus.rdata = 32'h0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Short asynchronous reset pulse inside the current cycle.
    task automatic do_reset();
        idle_inputs();
        resetn = 1'b0;
        #2;
        resetn = 1'b1;
    endtask

    task automatic run_vectors();
        for (int k = 0; k < 8; k++) begin
            do_reset();
            resetn = vecs[k].rst_n;
            inst_bus.req = vecs[k].i_req;
            inst_bus.addr = 32'h2000_0000 + 32'(k);
            inst_bus.wdata = 32'hAAAA_0000 + 32'(k);
            data_bus.req = vecs[k].d_req;
            data_bus.addr = 32'h1000_0000 + 32'(k);
            data_bus.wdata = 32'h5555_0000 + 32'(k);
            s_bus.addr_ok = vecs[k].aok;
            s_bus.data_ok = vecs[k].dok;
            s_bus.rdata = 32'hCAFE_0000 + 32'(k);
            @(negedge clk);
            check($sformatf("vec%0d s_req", k), 32'(s_bus.req), 32'(vecs[k].e_sreq));
            check($sformatf("vec%0d inst_addr_ok", k), 32'(inst_bus.addr_ok), 32'(vecs[k].e_iaok));
            check($sformatf("vec%0d data_addr_ok", k), 32'(data_bus.addr_ok), 32'(vecs[k].e_daok));
            check($sformatf("vec%0d inst_data_ok", k), 32'(inst_bus.data_ok), 32'h0);
            check($sformatf("vec%0d data_data_ok", k), 32'(data_bus.data_ok), 32'h0);
            if (vecs[k].e_sreq) begin
                check($sformatf("vec%0d s_addr", k), s_bus.addr,
                      vecs[k].e_sel_d ? 32'h1000_0000 + 32'(k) : 32'h2000_0000 + 32'(k));
                check($sformatf("vec%0d s_wdata", k), s_bus.wdata,
                      vecs[k].e_sel_d ? 32'h5555_0000 + 32'(k) : 32'hAAAA_0000 + 32'(k));
                check($sformatf("vec%0d s_wr", k), 32'(s_bus.wr), 32'(vecs[k].e_sel_d));
            end
            next_cycle();
            check($sformatf("vec%0d count", k), 32'(dbg_count), 32'(vecs[k].e_count));
            idle_inputs();
            resetn = 1'b1;
        end
    endtask

    task automatic seq_single_read();
        do_reset();
        inst_bus.req = 1'b1; inst_bus.addr = 32'hBFC0_0000; s_bus.addr_ok = 1'b1;
        @(negedge clk);
        check("rd inst_addr_ok", 32'(inst_bus.addr_ok), 32'h1);
        check("rd s_addr", s_bus.addr, 32'hBFC0_0000);
        check("rd c0 data_data_ok", 32'(data_bus.data_ok), 32'h0);
        next_cycle();
        inst_bus.req = 1'b0; s_bus.addr_ok = 1'b0;
        @(negedge clk);
        check("rd c1 inst_data_ok", 32'(inst_bus.data_ok), 32'h0);
        next_cycle();
        s_bus.data_ok = 1'b1; s_bus.rdata = 32'h3C01_0001;
        @(negedge clk);
        check("rd inst_data_ok", 32'(inst_bus.data_ok), 32'h1);
        check("rd inst_rdata", inst_bus.rdata, 32'h3C01_0001);
        check("rd c2 data_data_ok", 32'(data_bus.data_ok), 32'h0);
        next_cycle();
        idle_inputs();
        check("rd count", 32'(dbg_count), 32'h0);
    endtask

    task automatic seq_priority();
        do_reset();
        inst_bus.req = 1'b1; inst_bus.addr = 32'h2000;
        data_bus.req = 1'b1; data_bus.addr = 32'h1000; s_bus.addr_ok = 1'b1;
        @(negedge clk);
        check("pri s_addr data", s_bus.addr, 32'h1000);
        check("pri data_addr_ok", 32'(data_bus.addr_ok), 32'h1);
        check("pri inst_addr_ok c0", 32'(inst_bus.addr_ok), 32'h0);
        next_cycle();
        data_bus.req = 1'b0;
        @(negedge clk);
        check("pri s_addr inst", s_bus.addr, 32'h2000);
        check("pri inst_addr_ok", 32'(inst_bus.addr_ok), 32'h1);
        next_cycle();
        inst_bus.req = 1'b0; s_bus.addr_ok = 1'b0; s_bus.data_ok = 1'b1;
        @(negedge clk);
        check("pri resp1 data_data_ok", 32'(data_bus.data_ok), 32'h1);
        check("pri resp1 inst_data_ok", 32'(inst_bus.data_ok), 32'h0);
        next_cycle();
        @(negedge clk);
        check("pri resp2 inst_data_ok", 32'(inst_bus.data_ok), 32'h1);
        check("pri resp2 data_data_ok", 32'(data_bus.data_ok), 32'h0);
        next_cycle();
        idle_inputs();
    endtask

    task automatic seq_lock();
        do_reset();
        inst_bus.req = 1'b1; inst_bus.addr = 32'h5000;
        @(negedge clk);
        check("lock c0 s_addr", s_bus.addr, 32'h5000);
        next_cycle();
        check("lock state", 32'(dbg_lock), 32'h1);
        data_bus.req = 1'b1; data_bus.addr = 32'h6000;
        for (int c = 1; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("lock c%0d s_addr", c), s_bus.addr, 32'h5000);
            check($sformatf("lock c%0d data_addr_ok", c), 32'(data_bus.addr_ok), 32'h0);
            next_cycle();
        end
        s_bus.addr_ok = 1'b1;
        @(negedge clk);
        check("lock c3 s_addr", s_bus.addr, 32'h5000);
        check("lock c3 inst_addr_ok", 32'(inst_bus.addr_ok), 32'h1);
        check("lock c3 data_addr_ok", 32'(data_bus.addr_ok), 32'h0);
        next_cycle();
        inst_bus.req = 1'b0;
        check("lock released", 32'(dbg_lock), 32'h0);
        @(negedge clk);
        check("lock c4 s_addr", s_bus.addr, 32'h6000);
        check("lock c4 data_addr_ok", 32'(data_bus.addr_ok), 32'h1);
        next_cycle();
        idle_inputs();
    endtask

    task automatic seq_full();
        do_reset();
        data_bus.req = 1'b1; s_bus.addr_ok = 1'b1;
        for (int c = 0; c < 2; c++) begin
            data_bus.addr = 32'h3000 + 32'(4 * c);
            @(negedge clk);
            check($sformatf("full acc%0d data_addr_ok", c), 32'(data_bus.addr_ok), 32'h1);
            next_cycle();
        end
        check("full count", 32'(dbg_count), 32'h2);
        data_bus.addr = 32'h3008;
        for (int c = 2; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("full c%0d s_req", c), 32'(s_bus.req), 32'h0);
            check($sformatf("full c%0d data_addr_ok", c), 32'(data_bus.addr_ok), 32'h0);
            next_cycle();
        end
        s_bus.data_ok = 1'b1;
        @(negedge clk);
        check("full pop s_req", 32'(s_bus.req), 32'h0);
        check("full pop data_data_ok", 32'(data_bus.data_ok), 32'h1);
        next_cycle();
        s_bus.data_ok = 1'b0;
        check("full after pop count", 32'(dbg_count), 32'h1);
        @(negedge clk);
        check("full reopen s_req", 32'(s_bus.req), 32'h1);
        check("full reopen s_addr", s_bus.addr, 32'h3008);
        check("full reopen data_addr_ok", 32'(data_bus.addr_ok), 32'h1);
        next_cycle();
        idle_inputs();
        check("full refill count", 32'(dbg_count), 32'h2);
    endtask

    task automatic seq_push_pop();
        do_reset();
        inst_bus.req = 1'b1; inst_bus.addr = 32'h7000; s_bus.addr_ok = 1'b1;
        @(negedge clk);
        check("pp inst_addr_ok", 32'(inst_bus.addr_ok), 32'h1);
        next_cycle();
        inst_bus.req = 1'b0;
        check("pp count1", 32'(dbg_count), 32'h1);
        check("pp head inst", 32'(dbg_head), 32'h0);
        data_bus.req = 1'b1; data_bus.addr = 32'h4000;
        s_bus.data_ok = 1'b1; s_bus.rdata = 32'h1111_2222;
        @(negedge clk);
        check("pp data_addr_ok", 32'(data_bus.addr_ok), 32'h1);
        check("pp inst_data_ok", 32'(inst_bus.data_ok), 32'h1);
        check("pp data_data_ok", 32'(data_bus.data_ok), 32'h0);
        check("pp inst_rdata", inst_bus.rdata, 32'h1111_2222);
        next_cycle();
        idle_inputs();
        check("pp count kept", 32'(dbg_count), 32'h1);
        check("pp head data", 32'(dbg_head), 32'h1);
    endtask

    task automatic seq_reset_mid();
        do_reset();
        data_bus.req = 1'b1; data_bus.addr = 32'h8000; s_bus.addr_ok = 1'b1;
        next_cycle();
        next_cycle();
        check("rst pre count", 32'(dbg_count), 32'h2);
        s_bus.addr_ok = 1'b0;
        #1;
        resetn = 1'b0;
        #1;
        check("rst count now", 32'(dbg_count), 32'h0);
        s_bus.addr_ok = 1'b1; s_bus.data_ok = 1'b1;
        @(negedge clk);
        check("rst s_req", 32'(s_bus.req), 32'h0);
        check("rst data_addr_ok", 32'(data_bus.addr_ok), 32'h0);
        check("rst data_data_ok in reset", 32'(data_bus.data_ok), 32'h0);
        next_cycle();
        resetn = 1'b1;
        data_bus.req = 1'b0; s_bus.addr_ok = 1'b0;
        @(negedge clk);
        check("rst stale data_data_ok", 32'(data_bus.data_ok), 32'h0);
        check("rst stale inst_data_ok", 32'(inst_bus.data_ok), 32'h0);
        next_cycle();
        idle_inputs();
        check("rst post count", 32'(dbg_count), 32'h0);
    endtask

    // Random traffic against a model built from the arbitration rules:
    // a queue of issuer tags plus the master whose request is left waiting.
    task automatic run_random(input int n_cycles);
        bit exp_q [$];
        bit pend_v, pend_sel, i_req, d_req, aok, dok, exp_sreq, acc, resp, resp_head;
        int g;
        logic [31:0] i_addr, d_addr, rdata, exp_addr;
        do_reset();
        pend_v = 1'b0; pend_sel = 1'b0; i_req = 1'b0; d_req = 1'b0;
        i_addr = 32'h0; d_addr = 32'h0;
        for (int c = 0; c < n_cycles; c++) begin
            // Masters keep an unaccepted request stable; otherwise draw anew.
            if (!i_req) begin
                i_req = ($urandom_range(0, 99) < 45);
                i_addr = {$urandom_range(0, 32'hFFFF), 16'h0} | 32'h1;
            end
            if (!d_req) begin
                d_req = ($urandom_range(0, 99) < 35);
                d_addr = {$urandom_range(0, 32'hFFFF), 16'h0} | 32'h2;
            end
            aok = ($urandom_range(0, 99) < 60);
            dok = ($urandom_range(0, 99) < 45);
            rdata = $urandom;
            inst_bus.req = i_req; inst_bus.addr = i_addr;
            data_bus.req = d_req; data_bus.addr = d_addr;
            s_bus.addr_ok = aok; s_bus.data_ok = dok; s_bus.rdata = rdata;

            if (pend_v) g = pend_sel ? 2 : 1;
            else if (d_req) g = 2;
            else if (i_req) g = 1;
            else g = 0;
            exp_sreq = ((g == 2 && d_req) || (g == 1 && i_req)) && (exp_q.size() < OUTSTANDING);
            acc = exp_sreq && aok;
            resp = dok && (exp_q.size() > 0);
            resp_head = resp ? exp_q[0] : 1'b0;
            exp_addr = (g == 2) ? d_addr : i_addr;

            @(negedge clk);
            check($sformatf("rnd%0d s_req", c), 32'(s_bus.req), 32'(exp_sreq));
            if (exp_sreq) check($sformatf("rnd%0d s_addr", c), s_bus.addr, exp_addr);
            check($sformatf("rnd%0d inst_addr_ok", c), 32'(inst_bus.addr_ok), 32'(acc && g == 1));
            check($sformatf("rnd%0d data_addr_ok", c), 32'(data_bus.addr_ok), 32'(acc && g == 2));
            check($sformatf("rnd%0d inst_data_ok", c), 32'(inst_bus.data_ok), 32'(resp && !resp_head));
            check($sformatf("rnd%0d data_data_ok", c), 32'(data_bus.data_ok), 32'(resp && resp_head));
            check($sformatf("rnd%0d data_rdata", c), data_bus.rdata, rdata);
            next_cycle();

            if (resp) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(g == 2);
            pend_v = exp_sreq && !aok;
            pend_sel = (g == 2);
            if (acc && g == 1) i_req = 1'b0;
            if (acc && g == 2) d_req = 1'b0;
            check($sformatf("rnd%0d count", c), 32'(dbg_count), 32'(exp_q.size()));
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        resetn = 1'b0;
        next_cycle();
        check("reset s_req", 32'(s_bus.req), 32'h0);
        check("reset count", 32'(dbg_count), 32'h0);
        check("reset lock", 32'(dbg_lock), 32'h0);
        resetn = 1'b1;

        //           rst i  d  aok dok  sreq seld iaok daok count
        vecs[0] = mk(1, 1, 0, 1, 0,   1, 0, 1, 0, 2'd1);
        vecs[1] = mk(1, 0, 1, 1, 0,   1, 1, 0, 1, 2'd1);
        vecs[2] = mk(1, 1, 1, 1, 0,   1, 1, 0, 1, 2'd1);
        vecs[3] = mk(1, 0, 0, 1, 0,   0, 0, 0, 0, 2'd0);
        vecs[4] = mk(1, 1, 1, 0, 0,   1, 1, 0, 0, 2'd0);
        vecs[5] = mk(1, 1, 0, 1, 1,   1, 0, 1, 0, 2'd1);
        vecs[6] = mk(0, 1, 1, 1, 1,   0, 0, 0, 0, 2'd0);
        vecs[7] = mk(1, 0, 0, 0, 1,   0, 0, 0, 0, 2'd0);
        run_vectors();

        seq_single_read();
        seq_priority();
        seq_lock();
        seq_full();
        seq_push_pop();
        seq_reset_mid();
        run_random(400);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Watchdog: the bench never waits on the DUT open-endedly, but bound it anyway.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
